mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single word-wide memory port between NUM_REQ matcher stages in the match pipeline.
- Each requester uses the matcher memory protocol: ce/we/addr/width/data out, data/ready back. ce is held high across a multi-beat burst, and the address advances after each ready.
- Grants are locked for the whole burst. Arbitration between bursts is round-robin.
- A watchdog flags any requester that holds the port too long.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_HOLD, 64, max cycles one grant may persist before hold_err_o is raised

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- req_ce_i  input  NUM_REQ  per-requester memory enable / bus request
- req_we_i  input  NUM_REQ  per-requester write enable
- req_addr_i  input  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- req_width_i  input  NUM_REQ*4  packed access widths
- req_data_i  input  NUM_REQ*DATA_W  packed write data
- req_data_o  output  DATA_W  read data broadcast to all requesters
- req_ready_o  output  NUM_REQ  per-requester ready
- mem_ce_o  output  1  memory enable
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  memory address
- mem_width_o  output  4  access width
- mem_data_o  output  DATA_W  memory write data
- mem_data_i  input  DATA_W  memory read data
- mem_ready_i  input  1  memory beat complete
- grant_o  output  NUM_REQ  one-hot current grant (0 = none)
- busy_o  output  1  a grant is active
- hold_err_o  output  1  sticky watchdog error
- hold_err_id_o  output  3  requester index that tripped the watchdog

Behaviour:
- Reset (rst=0, async) forces the following, regardless of state or any burst in progress:
  - grant=0, state=IDLE, rr_ptr=0, hold_cnt=0, hold_err_o=0, hold_err_id_o=0
  - all mem_* outputs 0
  - req_ready_o=0, req_data_o=0
- States:
  - IDLE: no grant.
  - GRANT: registered one-hot grant g.
- IDLE transition: if any req_ce_i is set, pick the first set bit searching from rr_ptr upward with wrap. At the edge, grant=onehot(k), go to GRANT, hold_cnt=0.
- Request-to-grant latency is 1 cycle. mem_ce_o first rises in the cycle after the request is seen.
- GRANT datapath (combinational mux of requester g):
  - mem_ce_o = req_ce_i[g]; mem_we_o, mem_addr_o, mem_width_o, mem_data_o taken from requester g.
  - req_ready_o[g] = mem_ready_i; all other ready bits 0.
  - req_data_o = mem_data_i (broadcast).
- With no grant, all mem_* outputs are 0.
- Lock: the grant persists while req_ce_i[g]=1, across any number of ready beats. Non-granted requesters wait, with ready=0.
- Release happens at the first edge where req_ce_i[g]=0:
  - rr_ptr = (g+1) mod NUM_REQ.
  - If other requests are pending, re-arbitrate in the same edge from the new rr_ptr and stay in GRANT with the new grant and hold_cnt=0. There is no idle bubble.
  - Otherwise go to IDLE.
- A released requester re-raising ce in the same edge is eligible, but only after all others in round-robin order.
- Watchdog:
  - In GRANT, hold_cnt increments each cycle, saturating at MAX_HOLD.
  - When hold_cnt reaches MAX_HOLD-1 with ce still high: set hold_err_o=1 and hold_err_id_o=g (first error only, sticky until reset).
  - The grant is NOT revoked on error.
- mem_ready_i while in IDLE is ignored.
- busy_o = (state==GRANT).

Test Plan:
- Single request: req_ce_i=0010 at cycle 0, addr1=0x100. Required:
  - grant_o=0010 at cycle 1; mem_addr_o=0x100.
  - ready pulse seen only on req_ready_o[1].
  - Drop ce → grant_o=0 next cycle.
- Simultaneous: req_ce_i=0011 after reset (rr_ptr=0). Required:
  - req0 granted first.
  - On req0 ce drop, grant_o=0010 at the very next edge (no IDLE cycle).
- Fairness: all four ce held high, each burst = 3 beats then a 1-cycle ce drop. Required: grant order 0,1,2,3,0,…; each requester gets exactly 3 ready pulses per round.
- Burst lock: req2 bursts addr 0x40,0x44,0x48 while req0 requests mid-burst. Required:
  - mem_addr_o follows req2 exactly.
  - req_ready_o[0] stays 0 until req2 releases.
- Watchdog (MAX_HOLD=8): req3 holds ce for 20 cycles. Required:
  - hold_err_o=1, hold_err_id_o=3, after 8 grant cycles.
  - Grant retained throughout; error stays set after release.
- Async reset mid-burst: assert rst=0 between clock edges during a req1 burst. Required:
  - Immediately mem_ce_o=0, grant_o=0, req_ready_o=0.
  - After release, next arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory port between NUM_REQ matcher
// stages. A grant is held for the whole burst (while the owner keeps ce high).
// Bursts are arbitrated round-robin. A sticky watchdog records the first
// requester that keeps the port for MAX_HOLD cycles.
module mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_ce_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*4-1:0]      req_width_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [3:0]                mem_width_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i,
    input  logic                      mem_ready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      hold_err_o,
    output logic [2:0]                hold_err_id_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                 hold_err_q, hold_err_d;
    logic [2:0]           hold_err_id_q, hold_err_id_d;
    logic [IDX_W:0]       pick_s;
    logic [IDX_W-1:0]     rel_ptr_s;

    logic [ADDR_W-1:0]    addr_s  [NUM_REQ];
    logic [3:0]           width_s [NUM_REQ];
    logic [DATA_W-1:0]    wdata_s [NUM_REQ];

    // First requester set in req, searching upward from ptr with wrap.
    // Result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = {(IDX_W+1){1'b0}};
        // Walk from the farthest candidate back so the nearest one wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Index of the requester after idx, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_s[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
        assign width_s[k] = req_width_i[k*4 +: 4];
        assign wdata_s[k] = req_data_i[k*DATA_W +: DATA_W];
    end

    assign rel_ptr_s = next_idx(gidx_q);

    // State, grant, round-robin pointer and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= {NUM_REQ{1'b0}};
            gidx_q        <= {IDX_W{1'b0}};
            rr_ptr_q      <= {IDX_W{1'b0}};
            hold_cnt_q    <= {CNT_W{1'b0}};
            hold_err_q    <= 1'b0;
            hold_err_id_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_err_q    <= hold_err_d;
            hold_err_id_q <= hold_err_id_d;
        end
    end

    // Arbitration, burst lock, release with same-edge handover, watchdog.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        hold_err_d    = hold_err_q;
        hold_err_id_d = hold_err_id_q;
        pick_s        = {(IDX_W+1){1'b0}};
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = {CNT_W{1'b0}};
                pick_s     = rr_pick(req_ce_i, rr_ptr_q);
                if (pick_s[IDX_W]) begin
                    state_d = ST_GRANT;
                    gidx_d  = pick_s[IDX_W-1:0];
                    grant_d = onehot(pick_s[IDX_W-1:0]);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = {NUM_REQ{1'b0}};
                end
            end
            ST_GRANT: begin
                if (req_ce_i[gidx_q]) begin
                    // Burst still running: keep the grant, run the watchdog.
                    if (hold_cnt_q < CNT_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    if ((hold_cnt_q == CNT_W'(MAX_HOLD - 1)) && !hold_err_q) begin
                        hold_err_d    = 1'b1;
                        hold_err_id_d = 3'(gidx_q);
                    end else begin
                        hold_err_d    = hold_err_q;
                        hold_err_id_d = hold_err_id_q;
                    end
                end else begin
                    // Owner released: advance pointer past it, hand over at once.
                    rr_ptr_d   = rel_ptr_s;
                    hold_cnt_d = {CNT_W{1'b0}};
                    pick_s     = rr_pick(req_ce_i, rel_ptr_s);
                    if (pick_s[IDX_W]) begin
                        state_d = ST_GRANT;
                        gidx_d  = pick_s[IDX_W-1:0];
                        grant_d = onehot(pick_s[IDX_W-1:0]);
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = {NUM_REQ{1'b0}};
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = {NUM_REQ{1'b0}};
                hold_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Port datapath: mux the granted requester onto memory, route ready back.
    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_width_o = 4'd0;
        mem_data_o  = {DATA_W{1'b0}};
        req_ready_o = {NUM_REQ{1'b0}};
        req_data_o  = {DATA_W{1'b0}};
        if (state_q == ST_GRANT) begin
            mem_ce_o    = req_ce_i[gidx_q];
            mem_we_o    = req_we_i[gidx_q];
            mem_addr_o  = addr_s[gidx_q];
            mem_width_o = width_s[gidx_q];
            mem_data_o  = wdata_s[gidx_q];
            req_ready_o = grant_q & {NUM_REQ{mem_ready_i}};
            req_data_o  = mem_data_i;
        end else begin
            mem_ce_o    = 1'b0;
            req_ready_o = {NUM_REQ{1'b0}};
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state_q == ST_GRANT);
    assign hold_err_o    = hold_err_q;
    assign hold_err_id_o = hold_err_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios and a randomized phase,
// checked every cycle against a request-level reference model.
module tb_mem_port_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ce;
    logic [N-1:0]  we;
    logic [31:0]   addr_a  [N];
    logic [3:0]    width_a [N];
    logic [31:0]   wdata_a [N];
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    logic [N*32-1:0] req_addr_i;
    logic [N*4-1:0]  req_width_i;
    logic [N*32-1:0] req_data_i;
    logic [31:0]     req_data_o;
    logic [N-1:0]    req_ready_o;
    logic            mem_ce_o;
    logic            mem_we_o;
    logic [31:0]     mem_addr_o;
    logic [3:0]      mem_width_o;
    logic [31:0]     mem_data_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic            hold_err_o;
    logic [2:0]      hold_err_id_o;

    assign req_addr_i  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
    assign req_width_i = {width_a[3], width_a[2], width_a[1], width_a[0]};
    assign req_data_i  = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};

    mem_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_ce_i     (ce),
        .req_we_i     (we),
        .req_addr_i   (req_addr_i),
        .req_width_i  (req_width_i),
        .req_data_i   (req_data_i),
        .req_data_o   (req_data_o),
        .req_ready_o  (req_ready_o),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_width_o  (mem_width_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_rdata),
        .mem_ready_i  (mem_ready),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .hold_err_o   (hold_err_o),
        .hold_err_id_o(hold_err_id_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the port, where round-robin resumes,
    // how many cycles the owner has held it, and the sticky error.
    int   m_owner;
    int   m_rr;
    int   m_held;
    logic m_err;
    int   m_err_id;
    int   grant_log [$];
    int   beats   [N];
    int   rdy_cnt [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_rr     = 0;
        m_held   = 0;
        m_err    = 1'b0;
        m_err_id = 0;
    endtask

    // First pending requester in round-robin order starting at 'from'.
    function automatic int pick(input logic [N-1:0] req, input int from);
        int order [$];
        for (int i = 0; i < N; i++) order.push_back((from + i) % N);
        foreach (order[j]) begin
            if (req[2'(order[j])]) return order[j];
        end
        return -1;
    endfunction

    task automatic model_step();
        int k;
        if (m_owner < 0) begin
            k = pick(ce, m_rr);
            if (k >= 0) begin
                m_owner = k;
                m_held  = 0;
                grant_log.push_back(k);
            end
        end else if (ce[2'(m_owner)]) begin
            m_held++;
            if (m_held == MAX_HOLD && !m_err) begin
                m_err    = 1'b1;
                m_err_id = m_owner;
            end
        end else begin
            m_rr    = (m_owner + 1) % N;
            k       = pick(ce, m_rr);
            m_owner = k;
            m_held  = 0;
            if (k >= 0) grant_log.push_back(k);
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] g_e;
        logic [N-1:0] rdy_e;
        logic         ce_e;
        logic         we_e;
        logic [31:0]  a_e;
        logic [3:0]   w_e;
        logic [31:0]  d_e;
        logic [31:0]  rd_e;
        if (m_owner >= 0) begin
            g_e   = 4'b0001 << m_owner;
            ce_e  = ce[2'(m_owner)];
            we_e  = we[2'(m_owner)];
            a_e   = addr_a[2'(m_owner)];
            w_e   = width_a[2'(m_owner)];
            d_e   = wdata_a[2'(m_owner)];
            rdy_e = mem_ready ? g_e : 4'b0000;
            rd_e  = mem_rdata;
        end else begin
            g_e   = 4'b0000;
            ce_e  = 1'b0;
            we_e  = 1'b0;
            a_e   = 32'h0;
            w_e   = 4'h0;
            d_e   = 32'h0;
            rdy_e = 4'b0000;
            rd_e  = 32'h0;
        end
        chk("grant",     64'(grant_o),       64'(g_e));
        chk("busy",      64'(busy_o),        64'(m_owner >= 0));
        chk("mem_ce",    64'(mem_ce_o),      64'(ce_e));
        chk("mem_we",    64'(mem_we_o),      64'(we_e));
        chk("mem_addr",  64'(mem_addr_o),    64'(a_e));
        chk("mem_width", 64'(mem_width_o),   64'(w_e));
        chk("mem_wdata", 64'(mem_data_o),    64'(d_e));
        chk("ready",     64'(req_ready_o),   64'(rdy_e));
        chk("rdata",     64'(req_data_o),    64'(rd_e));
        chk("hold_err",  64'(hold_err_o),    64'(m_err));
        chk("hold_id",   64'(hold_err_id_o), 64'(m_err_id));
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return just after it so new stimulus can be applied.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        for (int k = 0; k < N; k++) rdy_cnt[2'(k)] += int'(req_ready_o[2'(k)]);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_owner >= 0 && mem_ready && ce[2'(m_owner)]) beats[2'(m_owner)]++;
            model_step();
        end
        #1;
    endtask

    task automatic do_reset();
        ce        = 4'b0000;
        mem_ready = 1'b0;
        rst       = 1'b0;
        #1;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        ce        = 4'b0000;
        we        = 4'b0000;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        for (int k = 0; k < N; k++) begin
            addr_a[k]  = 32'h0;
            width_a[k] = 4'h0;
            wdata_a[k] = 32'h0;
            beats[k]   = 0;
            rdy_cnt[k] = 0;
        end
        model_reset();
        #1;
        chk("rst_grant",  64'(grant_o),       64'(4'b0000));
        chk("rst_busy",   64'(busy_o),        64'(1'b0));
        chk("rst_mem_ce", 64'(mem_ce_o),      64'(1'b0));
        chk("rst_err",    64'(hold_err_o),    64'(1'b0));
        chk("rst_err_id", 64'(hold_err_id_o), 64'(3'd0));
        tick();
        tick();
        rst = 1'b1;

        // Single request: one cycle to grant, ready only to the owner.
        ce = 4'b0010; we = 4'b0010;
        addr_a[1] = 32'h100; width_a[1] = 4'h4; wdata_a[1] = 32'hA5A5_0001;
        #1;
        chk("a_no_grant_yet", 64'(grant_o), 64'(4'b0000));
        tick();
        chk("a_grant", 64'(grant_o),    64'(4'b0010));
        chk("a_addr",  64'(mem_addr_o), 64'(32'h100));
        chk("a_ce",    64'(mem_ce_o),   64'(1'b1));
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("a_ready", 64'(req_ready_o), 64'(4'b0010));
        chk("a_rdata", 64'(req_data_o),  64'(32'hDEAD_BEEF));
        tick();
        mem_ready = 1'b0; addr_a[1] = 32'h104; ce = 4'b0000;
        tick();
        chk("a_release", 64'(grant_o), 64'(4'b0000));
        chk("a_idle",    64'(busy_o),  64'(1'b0));

        // Simultaneous requests after reset: 0 first, then 1 with no bubble.
        do_reset();
        ce = 4'b0011; we = 4'b0000;
        tick();
        chk("b_first", 64'(grant_o), 64'(4'b0001));
        tick();
        tick();
        ce = 4'b0010;
        tick();
        chk("b_handover", 64'(grant_o), 64'(4'b0010));
        chk("b_busy",     64'(busy_o),  64'(1'b1));
        ce = 4'b0000;
        tick();
        tick();

        // Fairness: 3-beat bursts with a one-cycle ce drop between them.
        do_reset();
        grant_log.delete();
        for (int k = 0; k < N; k++) begin
            beats[k]   = 0;
            rdy_cnt[k] = 0;
        end
        ce = 4'b1111;
        for (int c = 0; c < 33; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (!ce[2'(k)]) begin
                    ce[2'(k)] = 1'b1;
                end else if (beats[k] >= 3) begin
                    ce[2'(k)] = 1'b0;
                    beats[k]  = 0;
                end
            end
            mem_ready = (m_owner >= 0) && ce[2'(m_owner)];
            mem_rdata = $urandom;
        end
        ce = 4'b0000; mem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("c_order%0d", i),
                64'((i < grant_log.size()) ? grant_log[i] : 9), 64'(i % 4));
        end
        for (int k = 0; k < N; k++) begin
            chk($sformatf("c_ready_pulses%0d", k), 64'(rdy_cnt[k]), 64'(6));
        end

        // Burst lock: req2 walks 0x40..0x48 while req0 waits.
        ce = 4'b0100; we = 4'b0100; addr_a[0] = 32'h900; addr_a[2] = 32'h40;
        tick();
        chk("d_grant", 64'(grant_o), 64'(4'b0100));
        mem_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            addr_a[2] = 32'h40 + 32'(4 * b);
            if (b == 1) ce = 4'b0101;
            #1;
            chk("d_addr",  64'(mem_addr_o),     64'(32'h40 + 32'(4 * b)));
            chk("d_rdy0",  64'(req_ready_o[0]), 64'(1'b0));
            chk("d_locked", 64'(grant_o),       64'(4'b0100));
            tick();
        end
        ce = 4'b0001; mem_ready = 1'b0;
        #1;
        chk("d_rdy0_end", 64'(req_ready_o[0]), 64'(1'b0));
        tick();
        chk("d_next", 64'(grant_o), 64'(4'b0001));
        ce = 4'b0000;
        tick();
        tick();

        // Watchdog: req3 holds for 20 cycles; error after 8 grant cycles.
        ce = 4'b1000; mem_ready = 1'b1;
        tick();
        chk("e_grant", 64'(grant_o),    64'(4'b1000));
        chk("e_err0",  64'(hold_err_o), 64'(1'b0));
        for (int j = 1; j < 20; j++) begin
            tick();
            chk($sformatf("e_err_after%0d", j), 64'(hold_err_o), 64'(j >= 8));
            chk("e_grant_kept", 64'(grant_o), 64'(4'b1000));
        end
        chk("e_err_id", 64'(hold_err_id_o), 64'(3'd3));
        ce = 4'b0000; mem_ready = 1'b0;
        tick();
        chk("e_released",  64'(grant_o),       64'(4'b0000));
        chk("e_err_stuck", 64'(hold_err_o),    64'(1'b1));
        chk("e_id_stuck",  64'(hold_err_id_o), 64'(3'd3));

        // Async reset in the middle of a req1 burst (pointer parked at 2).
        ce = 4'b0010; mem_ready = 1'b1;
        tick();
        tick();
        ce = 4'b0000; mem_ready = 1'b0;
        tick();
        ce = 4'b0010;
        tick();
        chk("f_grant1", 64'(grant_o), 64'(4'b0010));
        mem_ready = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("f_mem_ce", 64'(mem_ce_o),    64'(1'b0));
        chk("f_grant",  64'(grant_o),     64'(4'b0000));
        chk("f_ready",  64'(req_ready_o), 64'(4'b0000));
        chk("f_err",    64'(hold_err_o),  64'(1'b0));
        model_reset();
        ce = 4'b1111;
        tick();
        rst = 1'b1;
        tick();
        chk("f_rr_from0", 64'(grant_o), 64'(4'b0001));
        chk("f_model_rr", 64'(m_owner), 64'(0));
        ce = 4'b0000; mem_ready = 1'b0;
        tick();
        tick();

        // Randomized traffic with one asynchronous reset pulse.
        for (int c = 0; c < 600; c++) begin
            if (c == 301) rst = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (ce[2'(k)]) begin
                    if ($urandom_range(0, 5) == 0) ce[2'(k)] = 1'b0;
                end else begin
                    if ($urandom_range(0, 2) == 0) ce[2'(k)] = 1'b1;
                end
                addr_a[k]  = $urandom;
                width_a[k] = 4'($urandom_range(0, 15));
                wdata_a[k] = $urandom;
                we[2'(k)]  = 1'($urandom_range(0, 1));
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (c == 300) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
